// File: rtl/timer_sequencer_if.sv
// Avalon-MM master bus between timer_sequencer and the interval timer,
// including the timer's interrupt line.
interface timer_sequencer_if;
  logic [2:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [15:0] avm_writedata;
  logic        avm_waitrequest;
  logic        timer_irq;

  modport master (
    output avm_address,
    output avm_chipselect,
    output avm_write_n,
    output avm_writedata,
    input  avm_waitrequest,
    input  timer_irq
  );

  modport slave (
    input  avm_address,
    input  avm_chipselect,
    input  avm_write_n,
    input  avm_writedata,
    output avm_waitrequest,
    output timer_irq
  );
endinterface

// File: rtl/timer_sequencer.sv
// Round-robin sharing of one Avalon-MM interval timer between NUM_REQ clients:
// programs the timer for the owner, services its IRQ and pulses done per timeout.
module timer_sequencer #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [32*NUM_REQ-1:0]  req_period,
  input  logic [NUM_REQ-1:0]     req_continuous,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     done,
  output logic                   busy,
  output logic [IDX_W-1:0]       owner,
  timer_sequencer_if.master      avm
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_STOP, S_WR_PL, S_WR_PH, S_WR_CLR,
    S_WR_START, S_RUN, S_WR_ACK, S_MASK, S_WR_REL
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [31:0]          period_q, period_d;
  logic                 cont_q, cont_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 busy_q, busy_d;
  logic [2:0]           addr_q, addr_d;
  logic                 cs_q, cs_d;
  logic                 wn_q, wn_d;
  logic [15:0]          wdata_q, wdata_d;

  logic                 found_s;
  logic [IDX_W-1:0]     win_s;
  logic [31:0]          win_period_s;
  logic                 win_cont_s;
  logic [15:0]          period_lo_s;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] nxt;
    if (int'(idx) == NUM_REQ - 1) begin
      nxt = '0;
    end else begin
      nxt = idx + IDX_W'(1);
    end
    return nxt;
  endfunction

  // Round-robin scan of req starting at rr_ptr; first set bit wins.
  always_comb begin
    int scan;
    scan         = 0;
    found_s      = 1'b0;
    win_s        = '0;
    win_period_s = 32'd0;
    win_cont_s   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan = int'(rr_ptr_q) + i;
      scan = (scan >= NUM_REQ) ? (scan - NUM_REQ) : scan;
      if (!found_s && req[scan]) begin
        found_s      = 1'b1;
        win_s        = IDX_W'(scan);
        win_period_s = req_period[scan*32 +: 32];
        win_cont_s   = req_continuous[scan];
      end else begin
        found_s      = found_s;
      end
    end
  end

  // Sequencer next-state, ownership and done strobe.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    period_d = period_q;
    cont_d   = cont_q;
    grant_d  = grant_q;
    done_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          state_d  = S_WR_STOP;
          owner_d  = win_s;
          rr_ptr_d = wrap_inc(win_s);
          period_d = win_period_s;
          cont_d   = win_cont_s;
          grant_d  = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_s;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_WR_STOP:  state_d = avm.avm_waitrequest ? S_WR_STOP  : S_WR_PL;
      S_WR_PL:    state_d = avm.avm_waitrequest ? S_WR_PL    : S_WR_PH;
      S_WR_PH:    state_d = avm.avm_waitrequest ? S_WR_PH    : S_WR_CLR;
      S_WR_CLR:   state_d = avm.avm_waitrequest ? S_WR_CLR   : S_WR_START;
      S_WR_START: state_d = avm.avm_waitrequest ? S_WR_START : S_RUN;
      S_RUN: begin
        // IRQ outranks a simultaneous request drop so the timeout is still reported.
        if (avm.timer_irq) begin
          state_d = S_WR_ACK;
        end else if (!req[owner_q]) begin
          state_d = S_WR_REL;
        end else begin
          state_d = S_RUN;
        end
      end
      S_WR_ACK: begin
        if (!avm.avm_waitrequest) begin
          state_d = S_MASK;
          done_d  = grant_q;
        end else begin
          state_d = S_WR_ACK;
        end
      end
      // The timer's IRQ clear is registered, so the stale IRQ is skipped here.
      S_MASK:     state_d = (cont_q && req[owner_q]) ? S_RUN : S_WR_REL;
      S_WR_REL: begin
        if (!avm.avm_waitrequest) begin
          state_d = S_IDLE;
          grant_d = '0;
        end else begin
          state_d = S_WR_REL;
        end
      end
      default:    state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Bus outputs decoded from the next state so they are registered in step with it.
  always_comb begin
    period_lo_s = (period_d == 32'd0) ? 16'd1 : period_d[15:0];
    cs_d    = 1'b0;
    wn_d    = 1'b1;
    addr_d  = 3'd0;
    wdata_d = 16'h0000;
    case (state_d)
      S_WR_STOP, S_WR_REL: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wdata_d = 16'h0008;
      end
      S_WR_PL: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd2; wdata_d = period_lo_s;
      end
      S_WR_PH: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd3; wdata_d = period_d[31:16];
      end
      S_WR_CLR, S_WR_ACK: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd0; wdata_d = 16'h0000;
      end
      S_WR_START: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1;
        wdata_d = {13'd0, 1'b1, cont_d, 1'b1};
      end
      default: begin
        cs_d = 1'b0; wn_d = 1'b1; addr_d = 3'd0; wdata_d = 16'h0000;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      period_q <= 32'd0;
      cont_q   <= 1'b0;
      grant_q  <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      addr_q   <= 3'd0;
      cs_q     <= 1'b0;
      wn_q     <= 1'b1;
      wdata_q  <= 16'h0000;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      period_q <= period_d;
      cont_q   <= cont_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      addr_q   <= addr_d;
      cs_q     <= cs_d;
      wn_q     <= wn_d;
      wdata_q  <= wdata_d;
    end
  end

  assign grant              = grant_q;
  assign done               = done_q;
  assign busy               = busy_q;
  assign owner              = owner_q;
  assign avm.avm_address    = addr_q;
  assign avm.avm_chipselect = cs_q;
  assign avm.avm_write_n    = wn_q;
  assign avm.avm_writedata  = wdata_q;

endmodule

// File: tb/tb_timer_sequencer.sv
// Directed bench for timer_sequencer: one-shot, periodic, waitrequest stall,
// zero period, IRQ/req-drop collision, round-robin order and mid-write reset.
module tb_timer_sequencer;
  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NUM_REQ-1:0]    req;
  logic [32*NUM_REQ-1:0] req_period;
  logic [NUM_REQ-1:0]    req_continuous;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    done;
  logic                  busy;
  logic [IDX_W-1:0]      owner;
  int                    n_cmp = 0;
  int                    n_err = 0;

  timer_sequencer_if bus ();

  timer_sequencer #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .req_period     (req_period),
    .req_continuous (req_continuous),
    .grant          (grant),
    .done           (done),
    .busy           (busy),
    .owner          (owner),
    .avm            (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic [2:0] a, input logic [15:0] d);
    chk({tag, "/cs"},   32'(bus.avm_chipselect), 32'd1);
    chk({tag, "/wn"},   32'(bus.avm_write_n),    32'd0);
    chk({tag, "/addr"}, 32'(bus.avm_address),    32'(a));
    chk({tag, "/data"}, 32'(bus.avm_writedata),  32'(d));
  endtask

  task automatic chk_nowr(input string tag);
    chk({tag, "/cs"}, 32'(bus.avm_chipselect), 32'd0);
    chk({tag, "/wn"}, 32'(bus.avm_write_n),    32'd1);
  endtask

  task automatic serve_oneshot(input int o, input logic [15:0] pl, input int run_cycles);
    tick();
    chk("os_grant", 32'(grant), 32'd1 << o);
    chk("os_owner", 32'(owner), 32'(o));
    chk("os_busy",  32'(busy),  32'd1);
    chk_wr("os_stop", 3'd1, 16'h0008);
    tick(); chk_wr("os_pl",    3'd2, pl);
    tick(); chk_wr("os_ph",    3'd3, 16'h0000);
    tick(); chk_wr("os_clr",   3'd0, 16'h0000);
    tick(); chk_wr("os_start", 3'd1, 16'h0005);
    for (int k = 0; k < run_cycles; k++) begin
      tick();
      chk_nowr("os_run");
      chk("os_run_done", 32'(done), 32'd0);
    end
    bus.timer_irq = 1'b1;
    tick(); chk_wr("os_ack", 3'd0, 16'h0000);
    bus.timer_irq = 1'b0;
    tick();
    chk("os_done", 32'(done), 32'd1 << o);
    chk_nowr("os_mask");
    tick();
    chk("os_done_off", 32'(done), 32'd0);
    chk_wr("os_rel", 3'd1, 16'h0008);
    tick();
    chk("os_idle_grant", 32'(grant), 32'd0);
    chk("os_idle_busy",  32'(busy),  32'd0);
    chk_nowr("os_idle");
  endtask

  initial begin
    reset               = 1'b1;
    req                 = '0;
    req_period          = '0;
    req_continuous      = '0;
    bus.avm_waitrequest = 1'b0;
    bus.timer_irq       = 1'b0;
    tick(); tick();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_addr",  32'(bus.avm_address),   32'd0);
    chk("rst_data",  32'(bus.avm_writedata), 32'd0);
    chk_nowr("rst");
    reset = 1'b0;

    // Single one-shot on client 0, period 9.
    req = 4'b0001;
    req_period[31:0] = 32'd9;
    serve_oneshot(0, 16'h0009, 10);
    req = 4'b0000;

    // Periodic on client 2; period is sampled only at grant.
    req = 4'b0100;
    req_period[95:64] = 32'h0001_2345;
    req_continuous = 4'b0100;
    tick();
    chk("per_grant", 32'(grant), 32'h4);
    chk("per_owner", 32'(owner), 32'd2);
    chk_wr("per_stop", 3'd1, 16'h0008);
    req_period[95:64] = 32'hFFFF_FFFF;
    req_continuous = 4'b0000;
    tick(); chk_wr("per_pl",    3'd2, 16'h2345);
    tick(); chk_wr("per_ph",    3'd3, 16'h0001);
    tick(); chk_wr("per_clr",   3'd0, 16'h0000);
    tick(); chk_wr("per_start", 3'd1, 16'h0007);
    tick(); chk_nowr("per_run");
    for (int k = 0; k < 3; k++) begin
      tick(); tick();
      chk_nowr("per_wait");
      bus.timer_irq = 1'b1;
      tick(); chk_wr("per_ack", 3'd0, 16'h0000);
      tick();
      chk("per_done", 32'(done), 32'h4);
      bus.timer_irq = 1'b0;
      tick();
      chk("per_done_off", 32'(done),  32'd0);
      chk("per_grant_hold", 32'(grant), 32'h4);
      chk_nowr("per_rerun");
    end
    req = 4'b0000;
    tick(); chk_wr("per_rel", 3'd1, 16'h0008);
    tick();
    chk("per_idle_grant", 32'(grant), 32'd0);
    chk("per_idle_busy",  32'(busy),  32'd0);

    // Client 3: period 0 clamps to 1, waitrequest stall in PL, IRQ with req drop.
    req = 4'b1000;
    req_period[127:96] = 32'd0;
    req_continuous = 4'b1000;
    tick();
    chk("wt_grant", 32'(grant), 32'h8);
    chk_wr("wt_stop", 3'd1, 16'h0008);
    tick(); chk_wr("wt_pl", 3'd2, 16'h0001);
    bus.avm_waitrequest = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(); chk_wr("wt_pl_hold", 3'd2, 16'h0001);
    end
    bus.avm_waitrequest = 1'b0;
    tick(); chk_wr("wt_ph",    3'd3, 16'h0000);
    tick(); chk_wr("wt_clr",   3'd0, 16'h0000);
    tick(); chk_wr("wt_start", 3'd1, 16'h0007);
    tick(); chk_nowr("wt_run");
    bus.timer_irq = 1'b1;
    req = 4'b0000;
    tick(); chk_wr("col_ack", 3'd0, 16'h0000);
    bus.timer_irq = 1'b0;
    tick(); chk("col_done", 32'(done), 32'h8);
    tick(); chk_wr("col_rel", 3'd1, 16'h0008);
    tick();
    chk("col_idle_grant", 32'(grant), 32'd0);
    chk("col_idle_busy",  32'(busy),  32'd0);

    // Round-robin with all clients requesting one-shot timeouts.
    req = 4'b1111;
    req_continuous = 4'b0000;
    req_period = {4{32'd3}};
    serve_oneshot(0, 16'h0003, 1);
    serve_oneshot(1, 16'h0003, 1);
    serve_oneshot(2, 16'h0003, 1);
    serve_oneshot(3, 16'h0003, 1);
    serve_oneshot(0, 16'h0003, 1);

    // Reset during WR_PH, then arbitration restarts from pointer 0.
    req = 4'b0100;
    tick(); chk("rs_grant", 32'(grant), 32'h4);
    tick(); chk_wr("rs_pl", 3'd2, 16'h0003);
    tick(); chk_wr("rs_ph", 3'd3, 16'h0000);
    reset = 1'b1;
    tick();
    chk_nowr("rs_mid");
    chk("rs_grant0", 32'(grant), 32'd0);
    chk("rs_busy0",  32'(busy),  32'd0);
    chk("rs_done0",  32'(done),  32'd0);
    reset = 1'b0;
    req = 4'b1010;
    tick();
    chk("rs_regrant", 32'(grant), 32'h2);
    chk("rs_owner",   32'(owner), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
